// File: rtl/pg_domain_sequencer.sv
// Round-robin power-domain sequencer: issues one power-gate command at a time,
// waits for that domain's done, then enforces a settle gap before the next.
module pg_domain_sequencer #(
    parameter int unsigned N_DOM    = 4,
    parameter int unsigned SETTLE_W = 8,
    parameter int unsigned TIMEOUT  = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_DOM-1:0]         dom_req,
    input  logic [SETTLE_W-1:0]      settle_cycles,
    input  logic                     err_clr,
    input  logic [N_DOM-1:0]         pg_done,
    output logic [N_DOM-1:0]         pg_power,
    output logic [$clog2(N_DOM)-1:0] active_dom,
    output logic                     busy,
    output logic [N_DOM-1:0]         err,
    output logic                     all_stable
);

    localparam int unsigned AW = $clog2(N_DOM);
    localparam int unsigned IW = AW + 1;
    localparam int unsigned WW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_SETTLE = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [AW-1:0]       ptr;
    logic [WW-1:0]       wcnt;
    logic [SETTLE_W-1:0] scnt;

    logic [N_DOM-1:0]    cand;
    logic                found;
    logic [AW-1:0]       sel;
    logic [AW-1:0]       sel_inc;
    logic [IW-1:0]       idx_w;
    logic                done_hit;
    logic                time_hit;

    logic [N_DOM-1:0]    pg_power_nxt;
    logic [AW-1:0]       active_nxt;
    logic [AW-1:0]       ptr_nxt;
    logic [WW-1:0]       wcnt_nxt;
    logic [SETTLE_W-1:0] scnt_nxt;
    logic [N_DOM-1:0]    err_nxt;
    logic                busy_nxt;

    // Round-robin pick of the first mismatched, non-quarantined domain from ptr
    always_comb begin
        cand  = (dom_req ^ pg_power) & ~err;
        found = 1'b0;
        sel   = '0;
        idx_w = '0;
        for (int k = 0; k < N_DOM; k++) begin
            idx_w = {1'b0, ptr} + IW'(k);
            if (idx_w >= IW'(N_DOM)) begin
                idx_w = idx_w - IW'(N_DOM);
            end
            if (!found && cand[idx_w[AW-1:0]]) begin
                found = 1'b1;
                sel   = idx_w[AW-1:0];
            end
        end
        sel_inc = (sel == AW'(N_DOM - 1)) ? '0 : sel + AW'(1);
    end

    // Done on the first WAIT cycle is stale from the previous state and is ignored
    always_comb begin
        done_hit = (state == S_WAIT) && (wcnt != '0) && pg_done[active_dom];
        time_hit = (state == S_WAIT) && !done_hit && (wcnt == WW'(TIMEOUT - 1));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (found) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (done_hit || time_hit) begin
                    state_nxt = (settle_cycles == '0) ? S_IDLE : S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (scnt == SETTLE_W'(1)) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        pg_power_nxt = pg_power;
        active_nxt   = active_dom;
        ptr_nxt      = ptr;
        wcnt_nxt     = wcnt;
        scnt_nxt     = scnt;
        err_nxt      = err_clr ? '0 : err;
        busy_nxt     = (state_nxt != S_IDLE);
        case (state)
            S_IDLE: begin
                if (found) begin
                    pg_power_nxt[sel] = dom_req[sel];
                    active_nxt        = sel;
                    ptr_nxt           = sel_inc;
                    wcnt_nxt          = '0;
                end
            end
            S_WAIT: begin
                if (done_hit) begin
                    scnt_nxt = settle_cycles;
                end else if (time_hit) begin
                    err_nxt[active_dom] = 1'b1;
                    scnt_nxt            = settle_cycles;
                end else begin
                    wcnt_nxt = wcnt + WW'(1);
                end
            end
            S_SETTLE: begin
                scnt_nxt = scnt - SETTLE_W'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pg_power   <= '0;
            active_dom <= '0;
            ptr        <= '0;
            wcnt       <= '0;
            scnt       <= '0;
            err        <= '0;
            busy       <= 1'b0;
        end else begin
            pg_power   <= pg_power_nxt;
            active_dom <= active_nxt;
            ptr        <= ptr_nxt;
            wcnt       <= wcnt_nxt;
            scnt       <= scnt_nxt;
            err        <= err_nxt;
            busy       <= busy_nxt;
        end
    end

    assign all_stable = (state == S_IDLE) && (pg_power == dom_req) && (&pg_done);

endmodule

// File: tb/tb_pg_domain_sequencer.sv
// Bench for pg_domain_sequencer: power-gate FSM stand-ins plus a reference
// scheduler model, directed scenarios followed by random traffic.
module tb_pg_domain_sequencer;

    localparam int N   = 4;
    localparam int SW  = 8;
    localparam int TO  = 64;
    localparam int DLY = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  dom_req;
    logic [SW-1:0] settle_cycles;
    logic          err_clr;
    logic [N-1:0]  pg_done;
    logic [N-1:0]  pg_power;
    logic [1:0]    active_dom;
    logic          busy;
    logic [N-1:0]  err;
    logic          all_stable;

    pg_domain_sequencer #(.N_DOM(N), .SETTLE_W(SW), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .dom_req      (dom_req),
        .settle_cycles(settle_cycles),
        .err_clr      (err_clr),
        .pg_done      (pg_done),
        .pg_power     (pg_power),
        .active_dom   (active_dom),
        .busy         (busy),
        .err          (err),
        .all_stable   (all_stable)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // power-gate FSM stand-ins
    int           fsm_cnt [N];
    logic [N-1:0] fsm_seen;
    logic [N-1:0] stuck;

    // reference scheduler: in_flight domain, its age, remaining gap cycles
    logic [N-1:0] m_pwr;
    logic [N-1:0] m_err;
    int           m_act;
    int           m_ptr;
    int           m_age;
    int           m_gap;
    bit           m_busy;

    int order[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic ref_reset();
        m_pwr  = '0;
        m_err  = '0;
        m_act  = 0;
        m_ptr  = 0;
        m_age  = 0;
        m_gap  = 0;
        m_busy = 1'b0;
        for (int i = 0; i < N; i++) fsm_cnt[i] = 0;
        fsm_seen = '0;
        stuck    = '0;
        pg_done  = '1;
    endtask

    task automatic model_tick();
        bit fin;
        bit tmo;
        int pick;
        tmo = 1'b0;
        if (!m_busy) begin
            pick = -1;
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (m_ptr + k) % N;
                if (pick < 0 && dom_req[idx] != m_pwr[idx] && !m_err[idx]) pick = idx;
            end
            if (pick >= 0) begin
                m_pwr[pick] = dom_req[pick];
                m_act  = pick;
                m_ptr  = (pick + 1) % N;
                m_busy = 1'b1;
                m_age  = 0;
                m_gap  = 0;
            end
        end else if (m_gap > 0) begin
            m_gap--;
            if (m_gap == 0) m_busy = 1'b0;
        end else begin
            fin = (m_age > 0) && pg_done[m_act];
            tmo = !fin && (m_age == TO - 1);
            if (fin || tmo) begin
                if (settle_cycles == 0) m_busy = 1'b0;
                else m_gap = int'(settle_cycles);
            end else begin
                m_age++;
            end
        end
        if (err_clr) m_err = '0;
        if (tmo) m_err[m_act] = 1'b1;
    endtask

    task automatic compare_all(input logic [N-1:0] prev);
        logic exp_stable;
        exp_stable = !m_busy && (m_pwr == dom_req) && (&pg_done);
        check("pg_power",   32'(pg_power),   32'(m_pwr));
        check("active_dom", 32'(active_dom), 32'(m_act));
        check("busy",       32'(busy),       32'(m_busy));
        check("err",        32'(err),        32'(m_err));
        check("all_stable", 32'(all_stable), 32'(exp_stable));
        check("one_change", 32'($countones(pg_power ^ prev) <= 1), 32'(1));
    endtask

    // one clock: drive FSM dones, clock, advance model, compare; starts/ends at negedge
    task automatic step();
        logic [N-1:0] prev;
        for (int i = 0; i < N; i++) begin
            pg_done[i] = (fsm_cnt[i] == 0) && !stuck[i];
            if (pg_power[i] != fsm_seen[i]) begin
                fsm_seen[i] = pg_power[i];
                fsm_cnt[i]  = DLY;
            end else if (fsm_cnt[i] > 0) begin
                fsm_cnt[i]--;
            end
        end
        prev = pg_power;
        @(posedge clk);
        model_tick();
        #1;
        for (int i = 0; i < N; i++) if (pg_power[i] != prev[i]) order.push_back(i);
        compare_all(prev);
        @(negedge clk);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        ref_reset();
        check("rst_pg_power",   32'(pg_power),   32'(0));
        check("rst_busy",       32'(busy),       32'(0));
        check("rst_err",        32'(err),        32'(0));
        check("rst_active",     32'(active_dom), 32'(0));
        check("rst_all_stable", 32'(all_stable), 32'((m_pwr == dom_req) && (&pg_done)));
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst           = 1'b0;
        dom_req       = '0;
        err_clr       = 1'b0;
        settle_cycles = SW'(3);
        ref_reset();

        // reset with everything requested on; first command one cycle after release
        dom_req = 4'b1111;
        do_reset();
        step();
        check("t1_first_cmd", 32'(pg_power), 32'(4'b0001));

        // two domains on, serialised with settle gap
        dom_req = '0;
        do_reset();
        settle_cycles = SW'(3);
        dom_req = 4'b0101;
        order.delete();
        run(60);
        check("t2_power",  32'(pg_power),   32'(4'b0101));
        check("t2_stable", 32'(all_stable), 32'(1));
        check("t2_moves",  32'(order.size()), 32'(2));

        // hung domain 2 gets quarantined, then cleared
        dom_req = '0;
        do_reset();
        stuck[2] = 1'b1;
        dom_req  = 4'b0100;
        run(80);
        check("t3_err",   32'(err),      32'(4'b0100));
        check("t3_power", 32'(pg_power), 32'(4'b0100));
        check("t3_busy",  32'(busy),     32'(0));
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("t3_clr", 32'(err), 32'(0));
        stuck[2] = 1'b0;
        run(20);

        // round-robin from ptr=2
        dom_req = '0;
        do_reset();
        dom_req = 4'b0010;
        run(30);
        dom_req = 4'b0000;
        run(30);
        dom_req = 4'b1111;
        order.delete();
        run(150);
        begin
            int exp_ord[4];
            exp_ord = '{2, 3, 0, 1};
            check("t4_len", 32'(order.size()), 32'(4));
            for (int k = 0; k < order.size() && k < 4; k++)
                check("t4_order", 32'(order[k]), 32'(exp_ord[k]));
        end

        // request withdrawn mid-transition, zero settle gap
        dom_req = '0;
        do_reset();
        settle_cycles = SW'(0);
        dom_req = 4'b0010;
        order.delete();
        run(4);
        dom_req = 4'b0000;
        run(60);
        check("t5_power", 32'(pg_power),     32'(0));
        check("t5_moves", 32'(order.size()), 32'(2));

        // asynchronous reset in the middle of a WAIT on domain 1
        settle_cycles = SW'(2);
        dom_req = '0;
        do_reset();
        dom_req = 4'b1111;
        begin
            int guard;
            guard = 0;
            while (!(m_busy && m_gap == 0 && m_act == 1) && guard < 200) begin
                step();
                guard++;
            end
            check("t6_reach", 32'(guard < 200), 32'(1));
        end
        run(2);
        #2 rst = 1'b0;
        #1;
        check("t6_async_power",  32'(pg_power),   32'(0));
        check("t6_async_busy",   32'(busy),       32'(0));
        check("t6_async_active", 32'(active_dom), 32'(0));
        ref_reset();
        @(negedge clk);
        rst = 1'b1;
        step();
        check("t6_resume_dom",   32'(active_dom), 32'(0));
        check("t6_resume_power", 32'(pg_power),   32'(4'b0001));
        run(80);

        // random traffic
        dom_req = '0;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 15) == 0) dom_req = N'($urandom);
            err_clr = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 499) == 0) begin
                int d;
                d = $urandom_range(0, N - 1);
                stuck[d] = ~stuck[d];
            end
            if ($urandom_range(0, 299) == 0) settle_cycles = SW'($urandom_range(0, 5));
            step();
        end
        err_clr = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
